countdown_display_ctrl: RTL
===========================

# countdown_display_ctrl

Sequencing controller for the four-digit seven-segment countdown display. It holds an MM:SS value and decrements it once per second under load/start/pause control. It time-multiplexes the four digits onto the shared seven-segment decoder: one BCD nibble out and active-low anode enables. It sits between the board buttons/switches and the existing combinational BCD-to-segment decoder, which blanks any code above 9.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clk cycles per countdown tick (1 s at 100 MHz); must be ≥2.
- SCAN_DIV, 100_000: clk cycles per digit scan slot (1 ms); must be ≥2.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  one-cycle pulse; loads `preset`.
- preset  in  16  BCD digits [15:12]=M tens, [11:8]=M ones, [7:4]=S tens, [3:0]=S ones.
- start_stop  in  1  one-cycle pulse; toggles run/pause.
- digit  out  4  BCD code to the decoder's 4-bit input; 4'hF means blank.
- an  out  4  anode enables, active-low, one-hot-zero.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: value loaded, not counting.
  - RUN: prescaler advancing.
  - PAUSE: prescaler frozen.
  - DONE: value 00:00 reached.
- Valid preset: every digit ≤9 and S tens ≤5.
- Load, valid preset, any state: value ← preset; state → IDLE; prescaler ← 0.
- Load, invalid preset: value and state unchanged; load_err=1 for one cycle.
- start_stop transitions:
  - IDLE with value≠0000 → RUN.
  - IDLE with value=0000 → stays IDLE.
  - RUN → PAUSE.
  - PAUSE → RUN.
  - DONE: ignored.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and holds in PAUSE, so a partial second is kept. The tick fires in the cycle the prescaler equals TICK_DIV-1, and the prescaler then wraps to 0.
- Tick decrement is BCD with borrow:
  - S ones 0→9 with borrow.
  - S tens 0→5 with borrow.
  - M ones 0→9 with borrow.
  - M tens decrements.
- A tick producing 0000 moves the state to DONE in the same update.
- Simultaneous events:
  - load with start_stop: load wins and start_stop is dropped.
  - tick with start_stop in RUN: decrement is applied and state → PAUSE.
  - tick reaching 0000 with start_stop: DONE wins.
- Scan: a free-running counter, independent of state, advances the digit index 0→1→2→3→0 every SCAN_DIV cycles.
  - an = ~(4'b0001 << idx).
  - digit = value nibble idx.
  - Leading-zero blank: digit=4'hF when idx=3 and M tens=0.

## Timing
- Reset values:
  - value=0000, state=IDLE, prescaler=0.
  - scan counter=0, idx=0, an=4'b1110, digit=4'h0.
  - running=0, done=0, load_err=0.
- All state is updated on the rising clk edge. Outputs are decoded from registers only, with no input-to-output combinational path.
- Latencies:
  - load/start_stop pulse → state/value/running/done change visible the next cycle.
  - Tick cycle → new value visible the next cycle.
  - load_err is high the cycle after the bad load.
- From entering RUN with prescaler=0, the first decrement is visible TICK_DIV cycles later.
- Reset asserted mid-count immediately forces all reset values, including the scan position.
- Inputs are assumed synchronous, single-cycle pulses; debounce and synchronisation are upstream.

## Structure
- Package countdown_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - digit-index constants;
  - BCD limits (9, 5);
  - the BLANK code 4'hF.
- Sub-module bcd_mmss_dec: combinational 16-bit MM:SS BCD decrement with a `zero` output, instantiated once.
- The existing seven-segment decoder is instantiated outside this block.

## Test plan
All scenarios use TICK_DIV=4 and SCAN_DIV=2.
- Load 0x0102, then start_stop: after 3 ticks value=0x0059 and then 0x0058; done stays 0.
- Load 0x0002, then start_stop: done=1 and running=0 one cycle after the second tick; a further start_stop leaves the state DONE.
- RUN with prescaler=2, then start_stop: value is unchanged over 20 cycles; a second start_stop gives the next decrement 2 cycles later.
- Load 0x0070 (S tens=7): load_err pulses for one cycle and value is unchanged. Load and start_stop in the same cycle with 0x1234: state=IDLE.
- Scan with value 0x0930: an cycles 1110→1101→1011→0111 every 2 cycles, with digit 0,3,9,F respectively.
- Assert rst_n=0 mid-RUN: all outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown display controller.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Scan slot index -> value nibble shown in that slot
    localparam logic [1:0] IDX_S_ONES = 2'd0;
    localparam logic [1:0] IDX_S_TENS = 2'd1;
    localparam logic [1:0] IDX_M_ONES = 2'd2;
    localparam logic [1:0] IDX_M_TENS = 2'd3;

    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] BCD_MAX_STENS = 4'd5;
    localparam logic [3:0] BLANK         = 4'hF;

    // A preset is a legal MM:SS value: every digit decimal, seconds tens at most 5.
    function automatic logic preset_valid(input logic [15:0] p);
        return (p[15:12] <= BCD_MAX) && (p[11:8] <= BCD_MAX) &&
               (p[7:4] <= BCD_MAX_STENS) && (p[3:0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD MM:SS value.
// zero_o flags that the decremented result is 00:00.
module bcd_mmss_dec
    import countdown_pkg::*;
(
    input  logic [15:0] val_i,
    output logic [15:0] dec_o,
    output logic        zero_o
);

    logic b_sones, b_stens, b_mones;

    // Ripple the borrow from seconds ones up to minutes tens
    always_comb begin
        dec_o   = val_i;
        b_sones = 1'b0;
        b_stens = 1'b0;
        b_mones = 1'b0;

        if (val_i[3:0] == 4'd0) begin
            dec_o[3:0] = BCD_MAX;
            b_sones    = 1'b1;
        end else begin
            dec_o[3:0] = val_i[3:0] - 4'd1;
        end

        if (b_sones) begin
            if (val_i[7:4] == 4'd0) begin
                dec_o[7:4] = BCD_MAX_STENS;
                b_stens    = 1'b1;
            end else begin
                dec_o[7:4] = val_i[7:4] - 4'd1;
            end
        end

        if (b_stens) begin
            if (val_i[11:8] == 4'd0) begin
                dec_o[11:8] = BCD_MAX;
                b_mones     = 1'b1;
            end else begin
                dec_o[11:8] = val_i[11:8] - 4'd1;
            end
        end

        // 00:00 is never decremented by the controller; wrap to 9 keeps it BCD anyway
        if (b_mones) begin
            dec_o[15:12] = (val_i[15:12] == 4'd0) ? BCD_MAX : val_i[15:12] - 4'd1;
        end

        zero_o = (dec_o == 16'h0000);
    end

endmodule

// File: rtl/countdown_display_ctrl.sv
// MM:SS countdown controller: load/start/pause sequencing, 1 s prescaler,
// and four-digit multiplexed scan onto a shared BCD-to-segment decoder.
module countdown_display_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start_stop,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        running,
    output logic        done,
    output logic        load_err
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    state_e          state_q, state_d;
    logic [15:0]     value_q, value_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            load_err_q, load_err_d;
    logic [SW-1:0]   scan_q;
    logic [1:0]      idx_q;

    logic [15:0]     dec_val;
    logic            dec_zero;
    logic            tick;

    bcd_mmss_dec u_dec (
        .val_i  (value_q),
        .dec_o  (dec_val),
        .zero_o (dec_zero)
    );

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // Control state, value and prescaler registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            value_q    <= 16'h0000;
            presc_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            presc_q    <= presc_d;
            load_err_q <= load_err_d;
        end
    end

    // Next state: load has priority; a rejected load freezes everything but load_err.
    // A pausing start_stop without a tick keeps the prescaler where it is.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        presc_d    = presc_q;
        load_err_d = 1'b0;

        if (load) begin
            if (preset_valid(preset)) begin
                value_d = preset;
                state_d = ST_IDLE;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_stop && value_q != 16'h0000) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        value_d = dec_val;
                        if (dec_zero)        state_d = ST_DONE;
                        else if (start_stop) state_d = ST_PAUSE;
                    end else if (start_stop) begin
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    // Free-running digit scan, independent of the control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            idx_q  <= IDX_S_ONES;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            idx_q  <= idx_q + 2'd1;
        end else begin
            scan_q <= scan_q + SW'(1);
        end
    end

    // Output decode from registers only
    always_comb begin
        an    = ~(4'b0001 << idx_q);
        digit = value_q[{idx_q, 2'b00} +: 4];
        if (idx_q == IDX_M_TENS && value_q[15:12] == 4'd0) digit = BLANK;
        running  = (state_q == ST_RUN);
        done     = (state_q == ST_DONE);
        load_err = load_err_q;
    end

endmodule
